// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage request and pipeline control response bundle for pipe_ctrl_unit.
// master = ID/fetch side driving the decoded fields, slave = the control unit.
interface pipe_ctrl_unit_if #(
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned OPC_W = 11;
  localparam int unsigned CW_W  = 16;
  localparam int unsigned FWD_W = 2;

  logic [OPC_W-1:0]  opcode;
  logic              id_valid;
  logic [REG_AW-1:0] id_rn;
  logic [REG_AW-1:0] id_rm;
  logic [REG_AW-1:0] id_rd;
  logic              flush;

  logic              id_illegal;
  logic              stall;
  logic [CW_W-1:0]   ex_cw;
  logic [CW_W-1:0]   mem_cw;
  logic [CW_W-1:0]   wb_cw;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic [REG_AW-1:0] ex_ra;
  logic [REG_AW-1:0] ex_rb;
  logic [FWD_W-1:0]  fwd_a;
  logic [FWD_W-1:0]  fwd_b;

  modport master (
    output opcode, id_valid, id_rn, id_rm, id_rd, flush,
    input  id_illegal, stall, ex_cw, mem_cw, wb_cw,
           ex_rd, mem_rd, wb_rd, ex_ra, ex_rb, fwd_a, fwd_b
  );

  modport slave (
    input  opcode, id_valid, id_rn, id_rm, id_rd, flush,
    output id_illegal, stall, ex_cw, mem_cw, wb_cw,
           ex_rd, mem_rd, wb_rd, ex_ra, ex_rb, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode into a control word, carries it
// through EX/MEM/WB, and generates hazard stalls and EX operand forwarding selects.
module pipe_ctrl_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_REG = 30,
  parameter int unsigned ZERO_REG = 31,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_unit_if.slave   bus
);

  localparam int unsigned CW_W  = 16;
  localparam int unsigned FWD_W = 2;

  localparam int unsigned CW_UNCOND_BR = 0;
  localparam int unsigned CW_BRANCH    = 1;
  localparam int unsigned CW_REG2LOC   = 2;
  localparam int unsigned CW_ALU_SRC   = 3;
  localparam int unsigned CW_REG_WRITE = 4;
  localparam int unsigned CW_IMM       = 6;
  localparam int unsigned CW_MEM_TO_REG= 7;
  localparam int unsigned CW_MEM_WRITE = 8;
  localparam int unsigned CW_ALU_ON    = 10;
  localparam int unsigned CW_SET_FLAGS = 11;
  localparam int unsigned CW_BR_REG    = 12;
  localparam int unsigned CW_BR_LINK   = 13;
  localparam int unsigned CW_MEM_READ  = 14;
  localparam int unsigned CW_VALID     = 15;

  localparam logic [REG_AW-1:0] LINK_TAG = REG_AW'(LINK_REG);
  localparam logic [REG_AW-1:0] ZERO_TAG = REG_AW'(ZERO_REG);

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  logic [CW_W-1:0]   idCw;
  logic [REG_AW-1:0] idRa, idRb, idRd;
  logic              idLegal;

  logic [CW_W-1:0]   exCw, memCw, wbCw;
  logic [REG_AW-1:0] exRd, memRd, wbRd, exRa, exRb;

  logic exProd, memProd, wbProd;
  logic idHitEx, idHitMem;
  logic stallRaw, stallC;
  logic [FWD_W-1:0] fwdA, fwdB;

  // A source matches a producer only when it names a real register.
  function automatic logic srcHit(input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] rd,
                                  input logic              prod);
    return prod && (src != ZERO_TAG) && (src == rd);
  endfunction

  // Opcode decode, first matching row wins.
  always_comb begin
    idCw    = '0;
    idRa    = ZERO_TAG;
    idRb    = ZERO_TAG;
    idRd    = bus.id_rd;
    idLegal = 1'b1;
    if (bus.opcode[10:5] == 6'b000101) begin
      idCw[CW_UNCOND_BR] = 1'b1;
    end else if (bus.opcode[10:3] == 8'b01010100) begin
      idCw[CW_BRANCH] = 1'b1;
      idCw[CW_ALU_ON] = 1'b1;
    end else if (bus.opcode[10:5] == 6'b100101) begin
      idCw[CW_UNCOND_BR] = 1'b1;
      idCw[CW_BRANCH]    = 1'b1;
      idCw[CW_BR_LINK]   = 1'b1;
      idCw[CW_REG_WRITE] = 1'b1;
      idCw[CW_ALU_ON]    = 1'b1;
      idRd               = LINK_TAG;
    end else if (bus.opcode == 11'b11010110000) begin
      idCw[CW_BR_REG] = 1'b1;
      idCw[CW_ALU_ON] = 1'b1;
      idRa            = bus.id_rn;
    end else if (bus.opcode[10:3] == 8'b10110100) begin
      idCw[CW_BRANCH]    = 1'b1;
      idCw[CW_ALU_ON]    = 1'b1;
      idCw[CW_SET_FLAGS] = 1'b1;
      idRb               = bus.id_rd;
    end else if (bus.opcode[10:1] == 10'b1001000100) begin
      idCw[CW_ALU_SRC]   = 1'b1;
      idCw[CW_REG_WRITE] = 1'b1;
      idCw[CW_IMM]       = 1'b1;
      idCw[CW_ALU_ON]    = 1'b1;
      idRa               = bus.id_rn;
    end else if ((bus.opcode == 11'b10101011000) || (bus.opcode == 11'b11101011000)) begin
      idCw[CW_REG2LOC]   = 1'b1;
      idCw[CW_REG_WRITE] = 1'b1;
      idCw[CW_ALU_ON]    = 1'b1;
      idCw[CW_SET_FLAGS] = 1'b1;
      idRa               = bus.id_rn;
      idRb               = bus.id_rm;
    end else if (bus.opcode == 11'b11111000010) begin
      // Load address offset goes through the immediate path as well.
      idCw[CW_MEM_READ]   = 1'b1;
      idCw[CW_ALU_SRC]    = 1'b1;
      idCw[CW_REG_WRITE]  = 1'b1;
      idCw[CW_MEM_TO_REG] = 1'b1;
      idCw[CW_IMM]        = 1'b1;
      idCw[CW_ALU_ON]     = 1'b1;
      idRa                = bus.id_rn;
    end else if (bus.opcode == 11'b11111000000) begin
      idCw[CW_ALU_SRC]   = 1'b1;
      idCw[CW_MEM_WRITE] = 1'b1;
      idCw[CW_ALU_ON]    = 1'b1;
      idRa               = bus.id_rn;
      idRb               = bus.id_rd;
    end else begin
      idLegal = 1'b0;
    end
    idCw[CW_VALID] = idLegal & bus.id_valid;
  end

  assign exProd  = exCw[CW_VALID]  & exCw[CW_REG_WRITE]  & (exRd  != ZERO_TAG);
  assign memProd = memCw[CW_VALID] & memCw[CW_REG_WRITE] & (memRd != ZERO_TAG);
  assign wbProd  = wbCw[CW_VALID]  & wbCw[CW_REG_WRITE]  & (wbRd  != ZERO_TAG);

  assign idHitEx  = srcHit(idRa, exRd, exProd)   | srcHit(idRb, exRd, exProd);
  assign idHitMem = srcHit(idRa, memRd, memProd) | srcHit(idRb, memRd, memProd);

  // WB is never a hazard: the register file writes before it is read.
  always_comb begin
    if (FWD_EN) stallRaw = bus.id_valid & exCw[CW_MEM_READ] & idHitEx;
    else        stallRaw = bus.id_valid & (idHitEx | idHitMem);
  end

  assign stallC = stallRaw & ~bus.flush;

  // EX operand selects; MEM beats WB, and a load in MEM cannot forward yet.
  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    if (FWD_EN) begin
      if (srcHit(exRa, memRd, memProd) && !memCw[CW_MEM_READ]) fwdA = FWD_MEM;
      else if (srcHit(exRa, wbRd, wbProd))                      fwdA = FWD_WB;
      if (srcHit(exRb, memRd, memProd) && !memCw[CW_MEM_READ]) fwdB = FWD_MEM;
      else if (srcHit(exRb, wbRd, wbProd))                      fwdB = FWD_WB;
    end
  end

  // Stage registers; only EX can receive a bubble, downstream always advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      exCw  <= '0;
      exRd  <= '0;
      exRa  <= '0;
      exRb  <= '0;
      memCw <= '0;
      memRd <= '0;
      wbCw  <= '0;
      wbRd  <= '0;
    end else begin
      if (stallC || bus.flush || !bus.id_valid) begin
        exCw <= '0;
        exRd <= '0;
        exRa <= '0;
        exRb <= '0;
      end else begin
        exCw <= idCw;
        exRd <= idRd;
        exRa <= idRa;
        exRb <= idRb;
      end
      memCw <= exCw;
      memRd <= exRd;
      wbCw  <= memCw;
      wbRd  <= memRd;
    end
  end

  assign bus.id_illegal = bus.id_valid & ~idLegal;
  assign bus.stall      = stallC;
  assign bus.ex_cw      = exCw;
  assign bus.mem_cw     = memCw;
  assign bus.wb_cw      = wbCw;
  assign bus.ex_rd      = exRd;
  assign bus.mem_rd     = memRd;
  assign bus.wb_rd      = wbRd;
  assign bus.ex_ra      = exRa;
  assign bus.ex_rb      = exRb;
  assign bus.fwd_a      = fwdA;
  assign bus.fwd_b      = fwdB;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with forwarding, one without,
// both fed the same ID stream.
module tb_pipe_ctrl_unit;

  localparam int unsigned REG_AW = 5;

  localparam logic [10:0] OP_ADDI  = 11'h488;
  localparam logic [10:0] OP_ADDS  = 11'h558;
  localparam logic [10:0] OP_SUBS  = 11'h758;
  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [10:0] OP_B     = 11'h0A0;
  localparam logic [10:0] OP_BL    = 11'h4A0;
  localparam logic [10:0] OP_BR    = 11'h6B0;
  localparam logic [10:0] OP_CBZ   = 11'h5A0;
  localparam logic [10:0] OP_BCOND = 11'h2A0;
  localparam logic [10:0] OP_BAD   = 11'h7FF;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_ctrl_unit_if #(.REG_AW(REG_AW)) ifFwd ();
  pipe_ctrl_unit_if #(.REG_AW(REG_AW)) ifNoFwd ();

  pipe_ctrl_unit #(.REG_AW(REG_AW), .LINK_REG(30), .ZERO_REG(31), .FWD_EN(1'b1)) dutFwd (
    .clk(clk), .rst(rst), .bus(ifFwd)
  );

  pipe_ctrl_unit #(.REG_AW(REG_AW), .LINK_REG(30), .ZERO_REG(31), .FWD_EN(1'b0)) dutNoFwd (
    .clk(clk), .rst(rst), .bus(ifNoFwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setId(input logic [10:0] op, input logic v,
                       input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd);
    ifFwd.opcode   = op;  ifNoFwd.opcode   = op;
    ifFwd.id_valid = v;   ifNoFwd.id_valid = v;
    ifFwd.id_rn    = rn;  ifNoFwd.id_rn    = rn;
    ifFwd.id_rm    = rm;  ifNoFwd.id_rm    = rm;
    ifFwd.id_rd    = rd;  ifNoFwd.id_rd    = rd;
    #1;
  endtask

  task automatic setFlush(input logic f);
    ifFwd.flush = f;
    ifNoFwd.flush = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setId(11'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [10:0] op;
    logic [15:0] cw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifFwd.flush = 1'b0;
    ifNoFwd.flush = 1'b0;
    setId(11'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    // rn=1, rm=2, rd=10+i so no hazards arise in the stream
    vecs[0] = '{OP_ADDI,  16'h8458, 5'd1,  5'd31, 5'd10};
    vecs[1] = '{OP_ADDS,  16'h8C14, 5'd1,  5'd2,  5'd11};
    vecs[2] = '{OP_LDUR,  16'hC4D8, 5'd1,  5'd31, 5'd12};
    vecs[3] = '{OP_STUR,  16'h8508, 5'd1,  5'd13, 5'd13};
    vecs[4] = '{OP_SUBS,  16'h8C14, 5'd1,  5'd2,  5'd14};
    vecs[5] = '{OP_B,     16'h8001, 5'd31, 5'd31, 5'd15};
    vecs[6] = '{OP_BL,    16'hA413, 5'd31, 5'd31, 5'd30};
    vecs[7] = '{OP_BR,    16'h9400, 5'd1,  5'd31, 5'd17};
    vecs[8] = '{OP_CBZ,   16'h8C02, 5'd31, 5'd18, 5'd18};
    vecs[9] = '{OP_BCOND, 16'h8402, 5'd31, 5'd31, 5'd19};

    // Reset and idle
    doReset();
    checkEq("rst_ex_cw",  32'(ifFwd.ex_cw),  32'h0);
    checkEq("rst_mem_cw", 32'(ifFwd.mem_cw), 32'h0);
    checkEq("rst_wb_cw",  32'(ifFwd.wb_cw),  32'h0);
    checkEq("rst_stall",  32'(ifFwd.stall),  32'h0);
    checkEq("rst_fwd_a",  32'(ifFwd.fwd_a),  32'h0);
    checkEq("rst_fwd_b",  32'(ifFwd.fwd_b),  32'h0);
    checkEq("rst_stall_nf", 32'(ifNoFwd.stall), 32'h0);

    // Stream decode
    for (int i = 0; i < 10; i++) begin
      setId(vecs[i].op, 1'b1, 5'd1, 5'd2, 5'(10 + i));
      checkEq($sformatf("dec%0d_illegal", i), 32'(ifFwd.id_illegal), 32'h0);
      tick();
      checkEq($sformatf("dec%0d_ex_cw", i), 32'(ifFwd.ex_cw), 32'(vecs[i].cw));
      checkEq($sformatf("dec%0d_ex_ra", i), 32'(ifFwd.ex_ra), 32'(vecs[i].ra));
      checkEq($sformatf("dec%0d_ex_rb", i), 32'(ifFwd.ex_rb), 32'(vecs[i].rb));
      checkEq($sformatf("dec%0d_ex_rd", i), 32'(ifFwd.ex_rd), 32'(vecs[i].rd));
      if (i >= 2) checkEq($sformatf("dec%0d_wb_cw", i), 32'(ifFwd.wb_cw), 32'(vecs[i-2].cw));
    end
    setId(11'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    checkEq("idle_bubble_ex", 32'(ifFwd.ex_cw), 32'h0);
    checkEq("idle_mem_cw", 32'(ifFwd.mem_cw), 32'h8402);

    // Load-use: LDUR X2 then ADDS X3,X2,X4
    doReset();
    setId(OP_LDUR, 1'b1, 5'd1, 5'd0, 5'd2);
    checkEq("lu_nostall0", 32'(ifFwd.stall), 32'h0);
    tick();
    setId(OP_ADDS, 1'b1, 5'd2, 5'd4, 5'd3);
    checkEq("lu_stall", 32'(ifFwd.stall), 32'h1);
    tick();
    checkEq("lu_bubble", 32'(ifFwd.ex_cw), 32'h0);
    checkEq("lu_stall_done", 32'(ifFwd.stall), 32'h0);
    tick();
    checkEq("lu_ex_cw", 32'(ifFwd.ex_cw), 32'h8C14);
    checkEq("lu_fwd_a", 32'(ifFwd.fwd_a), 32'h2);
    checkEq("lu_fwd_b", 32'(ifFwd.fwd_b), 32'h0);

    // Forwarding priority: ADDI X5; ADDI X5; SUBS X6,X5,X5
    doReset();
    setId(OP_ADDI, 1'b1, 5'd1, 5'd0, 5'd5);
    tick();
    setId(OP_ADDI, 1'b1, 5'd1, 5'd0, 5'd5);
    tick();
    setId(OP_SUBS, 1'b1, 5'd5, 5'd5, 5'd6);
    checkEq("fp_nostall", 32'(ifFwd.stall), 32'h0);
    tick();
    checkEq("fp_ex_cw", 32'(ifFwd.ex_cw), 32'h8C14);
    checkEq("fp_fwd_a", 32'(ifFwd.fwd_a), 32'h1);
    checkEq("fp_fwd_b", 32'(ifFwd.fwd_b), 32'h1);

    // No forwarding: ADDI X1 then ADDS X2,X1,X1
    doReset();
    setId(OP_ADDI, 1'b1, 5'd3, 5'd0, 5'd1);
    tick();
    setId(OP_ADDS, 1'b1, 5'd1, 5'd1, 5'd2);
    checkEq("nf_stall1", 32'(ifNoFwd.stall), 32'h1);
    tick();
    checkEq("nf_bubble1", 32'(ifNoFwd.ex_cw), 32'h0);
    checkEq("nf_stall2", 32'(ifNoFwd.stall), 32'h1);
    tick();
    checkEq("nf_bubble2", 32'(ifNoFwd.ex_cw), 32'h0);
    checkEq("nf_stall_done", 32'(ifNoFwd.stall), 32'h0);
    tick();
    checkEq("nf_ex_cw", 32'(ifNoFwd.ex_cw), 32'h8C14);
    checkEq("nf_fwd_a", 32'(ifNoFwd.fwd_a), 32'h0);
    checkEq("nf_fwd_b", 32'(ifNoFwd.fwd_b), 32'h0);

    // Illegal opcode
    doReset();
    setId(OP_BAD, 1'b0, 5'd1, 5'd2, 5'd3);
    checkEq("ill_invalid", 32'(ifFwd.id_illegal), 32'h0);
    setId(OP_BAD, 1'b1, 5'd1, 5'd2, 5'd3);
    checkEq("ill_flag", 32'(ifFwd.id_illegal), 32'h1);
    tick();
    checkEq("ill_ex_cw", 32'(ifFwd.ex_cw), 32'h0);

    // Flush during a load-use stall
    doReset();
    setId(OP_LDUR, 1'b1, 5'd1, 5'd0, 5'd2);
    tick();
    setId(OP_ADDS, 1'b1, 5'd2, 5'd4, 5'd3);
    checkEq("fl_stall_pre", 32'(ifFwd.stall), 32'h1);
    setFlush(1'b1);
    checkEq("fl_stall", 32'(ifFwd.stall), 32'h0);
    tick();
    checkEq("fl_ex_cw", 32'(ifFwd.ex_cw), 32'h0);
    setFlush(1'b0);

    // X31 never hazards
    doReset();
    setId(OP_LDUR, 1'b1, 5'd1, 5'd0, 5'd31);
    tick();
    setId(OP_ADDS, 1'b1, 5'd31, 5'd31, 5'd3);
    checkEq("x31_stall", 32'(ifFwd.stall), 32'h0);
    checkEq("x31_stall_nf", 32'(ifNoFwd.stall), 32'h0);
    tick();
    checkEq("x31_ex_cw", 32'(ifFwd.ex_cw), 32'h8C14);

    // Mid-stream reset drops everything in flight
    setId(OP_ADDI, 1'b1, 5'd1, 5'd0, 5'd7);
    tick();
    rst = 1'b1;
    tick();
    checkEq("mrst_ex_cw",  32'(ifFwd.ex_cw),  32'h0);
    checkEq("mrst_mem_cw", 32'(ifFwd.mem_cw), 32'h0);
    checkEq("mrst_wb_cw",  32'(ifFwd.wb_cw),  32'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
